// File: rtl/trap_pkg.sv
// ============================================================================
// Module   : trap_pkg
// Purpose  : Cause codes, opcode/SYSTEM encodings and FSM state type for the
//            trap controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package trap_pkg;

    localparam logic [7:0] CAUSE_MISALIGNED = 8'h00;
    localparam logic [7:0] CAUSE_ILLEGAL    = 8'h02;
    localparam logic [7:0] CAUSE_ECALL      = 8'h0B;
    localparam logic [7:0] CAUSE_IRQ_BASE   = 8'h80;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_e;

    // SYSTEM opcode is only accepted as the exact ECALL or MRET word.
    function automatic logic inst_is_legal(input logic [31:0] inst);
        logic [6:0] opc;
        opc = inst[6:0];
        return (opc == OPC_OP)     || (opc == OPC_OP_IMM) || (opc == OPC_LOAD)  ||
               (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_JAL)   ||
               (opc == OPC_JALR)   || (opc == OPC_LUI)    || (opc == OPC_AUIPC) ||
               (inst == INST_ECALL) || (inst == INST_MRET);
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_pending_arbiter.sv
// ============================================================================
// Module   : irq_pending_arbiter
// Purpose  : Rising-edge interrupt latch with per-bit clear and lowest-index
//            priority encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_pending_arbiter #(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] clr_i,
    output logic               valid_o,
    output logic [3:0]         index_o
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] edge_w;

    assign edge_w = irq_i & ~irq_q;

    // A fresh edge wins over a clear landing on the same bit.
    assign pending_d = (pending_q & ~clr_i) | edge_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= '0;
            pending_q <= '0;
        end else begin
            irq_q     <= irq_i;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        valid_o = 1'b0;
        index_o = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                valid_o = 1'b1;
                index_o = 4'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/trap_controller.sv
// ============================================================================
// Module   : trap_controller
// Purpose  : Sequential exception/interrupt/MRET controller with a
//            flush/redirect handshake. TRAP_VECTORED_EN selects vectored IRQs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trap_controller
    import trap_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NUM_IRQ   = 4,
    parameter logic [XLEN-1:0] TRAP_BASE = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [31:0]        id_inst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               pipe_ack,
    output logic               trap_flush,
    output logic               trap_redirect,
    output logic [XLEN-1:0]    trap_target,
    output logic [XLEN-1:0]    mepc_o,
    output logic [7:0]         mcause_o,
    output logic               mie_o,
    output logic               in_trap
);

    trap_state_e        state_q, state_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    target_q, target_d;
    logic [7:0]         mcause_q, mcause_d;
    logic               mie_q, mie_d;
    logic               in_trap_q, in_trap_d;
    logic [NUM_IRQ-1:0] irq_clr_w;
    logic               irq_valid_w;
    logic [3:0]         irq_index_w;
    logic [XLEN-1:0]    irq_target_w;
    logic               is_mret_w;
    logic               is_ecall_w;

    irq_pending_arbiter #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_i   (irq_i),
        .clr_i   (irq_clr_w),
        .valid_o (irq_valid_w),
        .index_o (irq_index_w)
    );

`ifdef TRAP_VECTORED_EN
    assign irq_target_w = TRAP_BASE + (XLEN'(irq_index_w) << 2);
`else
    assign irq_target_w = TRAP_BASE;
`endif

    assign is_mret_w  = (id_inst == INST_MRET);
    assign is_ecall_w = (id_inst == INST_ECALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mepc_q    <= '0;
            target_q  <= '0;
            mcause_q  <= '0;
            mie_q     <= 1'b1;
            in_trap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mepc_q    <= mepc_d;
            target_q  <= target_d;
            mcause_q  <= mcause_d;
            mie_q     <= mie_d;
            in_trap_q <= in_trap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mepc_d    = mepc_q;
        target_d  = target_q;
        mcause_d  = mcause_q;
        mie_d     = mie_q;
        in_trap_d = in_trap_q;
        irq_clr_w = '0;

        case (state_q)
            ST_IDLE: begin
                if (id_valid) begin
                    // Any trap shares the same save/mask sequence; only cause and target differ.
                    if (irq_valid_w && mie_q) begin
                        mcause_d  = CAUSE_IRQ_BASE | {4'd0, irq_index_w};
                        target_d  = irq_target_w;
                        irq_clr_w = NUM_IRQ'(1) << irq_index_w;
                        state_d   = ST_FLUSH;
                    end else if (id_pc[1:0] != 2'b00) begin
                        mcause_d = CAUSE_MISALIGNED;
                        target_d = TRAP_BASE;
                        state_d  = ST_FLUSH;
                    end else if (!inst_is_legal(id_inst) || (is_mret_w && !in_trap_q)) begin
                        mcause_d = CAUSE_ILLEGAL;
                        target_d = TRAP_BASE;
                        state_d  = ST_FLUSH;
                    end else if (is_ecall_w) begin
                        mcause_d = CAUSE_ECALL;
                        target_d = TRAP_BASE;
                        state_d  = ST_FLUSH;
                    end else if (is_mret_w) begin
                        mie_d     = 1'b1;
                        in_trap_d = 1'b0;
                        target_d  = mepc_q;
                        state_d   = ST_FLUSH;
                    end

                    if (state_d == ST_FLUSH && !(is_mret_w && in_trap_q && mcause_d == mcause_q
                                                 && target_d == mepc_q && !mie_q && mie_d)) begin
                        mepc_d    = id_pc;
                        mie_d     = 1'b0;
                        in_trap_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (pipe_ack) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign trap_flush    = (state_q == ST_FLUSH);
    assign trap_redirect = (state_q == ST_REDIRECT);
    assign trap_target   = trap_redirect ? target_q : '0;
    assign mepc_o        = mepc_q;
    assign mcause_o      = mcause_q;
    assign mie_o         = mie_q;
    assign in_trap       = in_trap_q;

endmodule

`default_nettype wire
